// File: rtl/thr_det_pkg.sv
// Shared types and limits for the accumulator threshold detector.
// Optional trip-event counter is enabled by defining THR_EVENT_COUNT_EN.
package thr_det_pkg;

    localparam int ST_W         = 2;
    localparam int DEBOUNCE_MAX = 255;

    typedef enum logic [ST_W-1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        TRIPPED = 2'd2
    } state_t;

endpackage

// File: rtl/debounce_counter.sv
// Counts consecutive qualifying samples; hit is combinational on the DEBOUNCE-th one.
// Latency: hit in the same cycle as the terminal sample; no backpressure.
// Backpressure: none, one sample consumed every cycle.
module debounce_counter
    import thr_det_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic qualify,
    input  logic clear,
    output logic hit
);

    localparam int CW = $clog2(DEBOUNCE_MAX + 1);

    logic [CW-1:0] cnt;

    // Terminal count is seen before the register updates, so the FSM can
    // change state on the very edge that registers the qualifying sample.
    assign hit = qualify && (cnt == CW'(DEBOUNCE - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || !qualify) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/accum_threshold_detector.sv
// Hysteresis alarm on the accumulator sum with debounced trip/release; optional trip counter (THR_EVENT_COUNT_EN).
// Latency: alarm/alarm_pulse registered, high after the edge that registers the DEBOUNCE-th qualifying sample.
// Backpressure: none; samples every cycle, no handshake.
module accum_threshold_detector
    import thr_det_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] thr_hi,
    input  logic [WIDTH-1:0] thr_lo,
    output logic             alarm,
    output logic             alarm_pulse,
    output logic [ST_W-1:0]  state,
    output logic [CNT_W-1:0] event_cnt
);

    state_t state_q;
    state_t state_d;
    logic   qualify;
    logic   hit;
    logic   clear;
    logic   trip;

    // Trip phase looks at thr_hi, release phase at thr_lo; en/clr mask the compare.
    assign qualify = en && !clr &&
                     (((state_q == ARMED)   && (acc_in >= thr_hi)) ||
                      ((state_q == TRIPPED) && (acc_in <= thr_lo)));

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else if (clr) begin
            case (state_q)
                IDLE:    state_d = IDLE;
                ARMED:   state_d = ARMED;
                TRIPPED: state_d = ARMED;
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE:    state_d = ARMED;
                ARMED:   state_d = hit ? TRIPPED : ARMED;
                TRIPPED: state_d = hit ? ARMED : TRIPPED;
                default: state_d = IDLE;
            endcase
        end
    end

    // One counter serves both phases, so it restarts on every state change.
    assign clear = !en || clr || (state_d != state_q);
    assign trip  = (state_q == ARMED) && (state_d == TRIPPED);

    debounce_counter #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .qualify (qualify),
        .clear   (clear),
        .hit     (hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            alarm       <= 1'b0;
            alarm_pulse <= 1'b0;
        end else begin
            state_q     <= state_d;
            alarm       <= (state_d == TRIPPED);
            alarm_pulse <= trip;
        end
    end

    assign state = state_q;

`ifdef THR_EVENT_COUNT_EN
    logic [CNT_W-1:0] ev_q;

    // en=0 outranks clr, so a clear issued while disabled is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ev_q <= '0;
        end else if (en) begin
            if (clr) begin
                ev_q <= '0;
            end else if (trip && (ev_q != {CNT_W{1'b1}})) begin
                ev_q <= ev_q + 1'b1;
            end
        end
    end

    assign event_cnt = ev_q;
`else
    assign event_cnt = '0;
`endif

endmodule

// File: tb/tb_accum_threshold_detector.sv
// Directed bench for accum_threshold_detector: DEBOUNCE=4, thr_hi=1000, thr_lo=0800, CNT_W=2.
module tb_accum_threshold_detector;

    logic        clk;
    logic        reset;
    logic        en;
    logic        clr;
    logic [15:0] acc_in;
    logic [15:0] thr_hi;
    logic [15:0] thr_lo;
    logic        alarm;
    logic        alarm_pulse;
    logic [1:0]  state;
    logic [1:0]  event_cnt;

    int total;
    int bad;
    int exp_ev;

    accum_threshold_detector #(
        .WIDTH    (16),
        .DEBOUNCE (4),
        .CNT_W    (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .clr         (clr),
        .acc_in      (acc_in),
        .thr_hi      (thr_hi),
        .thr_lo      (thr_lo),
        .alarm       (alarm),
        .alarm_pulse (alarm_pulse),
        .state       (state),
        .event_cnt   (event_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected trip count model: saturates at 3 with the counter built in, else always 0.
    task automatic note_trip();
`ifdef THR_EVENT_COUNT_EN
        if (exp_ev < 3) exp_ev++;
`endif
    endtask

    task automatic check_ev(input string tag);
        check(tag, {14'd0, event_cnt}, exp_ev[15:0]);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        exp_ev = 0;
        thr_hi = 16'h1000;
        thr_lo = 16'h0800;
        en     = 1'b1;
        clr    = 1'b0;
        acc_in = 16'hFFFF;
        reset  = 1'b0;

        // Reset held across edges with qualifying input
        repeat (3) tick();
        check("rst_state", {14'd0, state}, 16'd0);
        check("rst_alarm", {15'd0, alarm}, 16'd0);
        check("rst_pulse", {15'd0, alarm_pulse}, 16'd0);
        check_ev("rst_ev");

        reset  = 1'b1;
        acc_in = 16'h0000;
        tick();
        check("arm_after_rst", {14'd0, state}, 16'd1);

        // Trip: four samples at exactly thr_hi
        acc_in = 16'h1000;
        repeat (3) tick();
        check("trip_3rd_no_alarm", {15'd0, alarm}, 16'd0);
        tick();
        note_trip();
        check("trip_alarm", {15'd0, alarm}, 16'd1);
        check("trip_pulse", {15'd0, alarm_pulse}, 16'd1);
        check("trip_state", {14'd0, state}, 16'd2);
        check_ev("trip_ev");
        tick();
        check("pulse_one_cycle", {15'd0, alarm_pulse}, 16'd0);
        check("alarm_held", {15'd0, alarm}, 16'd1);

        // Just above thr_lo never releases
        acc_in = 16'h0801;
        repeat (10) tick();
        check("hyst_0801_alarm", {15'd0, alarm}, 16'd1);

        // Release: four samples at exactly thr_lo
        acc_in = 16'h0800;
        repeat (3) tick();
        check("rel_3rd_alarm", {15'd0, alarm}, 16'd1);
        tick();
        check("rel_alarm", {15'd0, alarm}, 16'd0);
        check("rel_state", {14'd0, state}, 16'd1);
        check("rel_no_pulse", {15'd0, alarm_pulse}, 16'd0);

        // Debounce broken by 0FFF, then restarted
        acc_in = 16'h1000; tick();
        acc_in = 16'h1200; tick();
        acc_in = 16'h1300; tick();
        acc_in = 16'h0FFF; tick();
        acc_in = 16'h1000;
        repeat (3) tick();
        check("break_no_trip", {15'd0, alarm}, 16'd0);
        check("break_state", {14'd0, state}, 16'd1);
        tick();
        note_trip();
        check("break_trip_alarm", {15'd0, alarm}, 16'd1);
        check("break_trip_pulse", {15'd0, alarm_pulse}, 16'd1);
        check_ev("break_trip_ev");

        // Synchronous clear while tripped
        clr    = 1'b1;
        acc_in = 16'h0000;
        tick();
        clr    = 1'b0;
`ifdef THR_EVENT_COUNT_EN
        exp_ev = 0;
`endif
        check("clr_state", {14'd0, state}, 16'd1);
        check("clr_alarm", {15'd0, alarm}, 16'd0);
        check("clr_pulse", {15'd0, alarm_pulse}, 16'd0);
        check_ev("clr_ev");

        // en=0 in the middle of a trip debounce
        acc_in = 16'h1000;
        repeat (2) tick();
        en = 1'b0;
        tick();
        check("dis_state", {14'd0, state}, 16'd0);
        check("dis_pulse", {15'd0, alarm_pulse}, 16'd0);
        en = 1'b1;
        tick();
        check("reen_state", {14'd0, state}, 16'd1);
        repeat (3) tick();
        check("reen_cnt_cleared", {15'd0, alarm}, 16'd0);
        tick();
        note_trip();
        check("reen_trip", {15'd0, alarm}, 16'd1);
        check_ev("reen_ev");

        // Async reset mid-TRIPPED, observed before the next edge
        tick();
        #2;
        reset = 1'b0;
        #1;
        exp_ev = 0;
        check("arst_alarm", {15'd0, alarm}, 16'd0);
        check("arst_state", {14'd0, state}, 16'd0);
        check("arst_pulse", {15'd0, alarm_pulse}, 16'd0);
        check_ev("arst_ev");
        tick();
        reset  = 1'b1;
        acc_in = 16'h0000;
        tick();

        // Five trip/release cycles; counter saturates at 3
        for (int t = 0; t < 5; t++) begin
            acc_in = 16'h1000;
            repeat (4) tick();
            note_trip();
            check("sat_trip", {15'd0, alarm_pulse}, 16'd1);
            check_ev("sat_ev");
            acc_in = 16'hFFFF;
            tick();
            acc_in = 16'h0000;
            repeat (4) tick();
            check("sat_release", {14'd0, state}, 16'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
